// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. Each resolve produces a
// one-cycle training update and mispredict pulse, and a mispredict flushes the queue.
module branch_resolve_queue #(
    parameter int PC_WIDTH  = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic [PC_WIDTH-1:0]        pred_pc,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       res_ready,
    output logic                       upd_valid,
    output logic [PC_WIDTH-1:0]        upd_pc,
    output logic                       upd_outcome,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_WIDTH-1:0]       branch_count,
    output logic [CNT_WIDTH-1:0]       mispredict_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [PC_WIDTH-1:0] pc_mem [DEPTH];
    logic [DEPTH-1:0]    taken_mem;
    logic [AW-1:0]       head;
    logic [AW-1:0]       tail;
    logic                push;
    logic                pop;
    logic                flush;

    assign pred_ready = (occupancy < OCC_FULL);
    assign res_ready  = (occupancy != '0);
    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && res_ready;
    assign flush      = pop && (taken_mem[head] != res_taken);

    // Storage needs no reset; a flushing edge drops the wrong-path enqueue.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[tail]    <= pred_pc;
            taken_mem[tail] <= pred_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head             <= '0;
            tail             <= '0;
            occupancy        <= '0;
            upd_valid        <= 1'b0;
            upd_pc           <= '0;
            upd_outcome      <= 1'b0;
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            upd_valid  <= pop;
            mispredict <= flush;
            if (pop) begin
                upd_pc      <= pc_mem[head];
                upd_outcome <= res_taken;
                if (branch_count != '1)
                    branch_count <= branch_count + CNT_WIDTH'(1);
            end
            if (flush && mispredict_count != '1)
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);

            if (flush) begin
                head      <= tail;
                occupancy <= '0;
            end else begin
                if (push)
                    tail <= tail + AW'(1);
                if (pop)
                    head <= head + AW'(1);
                case ({push, pop})
                    2'b10:   occupancy <= occupancy + (AW+1)'(1);
                    2'b01:   occupancy <= occupancy - (AW+1)'(1);
                    default: occupancy <= occupancy;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_branch_resolve_queue;
    localparam int PW = 8;
    localparam int DP = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pred_valid = 1'b0;
    logic [PW-1:0] pred_pc = '0;
    logic          pred_taken = 1'b0;
    logic          pred_ready;
    logic          res_valid = 1'b0;
    logic          res_taken = 1'b0;
    logic          res_ready;
    logic          upd_valid;
    logic [PW-1:0] upd_pc;
    logic          upd_outcome;
    logic          mispredict;
    logic [2:0]    occupancy;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    int n_checks = 0;
    int n_pass = 0;

    // reference model state
    int m_pc[$];
    int m_tk[$];
    int m_bc, m_mc, m_upd_pc;
    bit m_upd_valid, m_upd_out, m_mis;

    branch_resolve_queue #(.PC_WIDTH(PW), .DEPTH(DP), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_outcome(upd_outcome),
        .mispredict(mispredict), .occupancy(occupancy),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc.delete();
        m_tk.delete();
        m_bc = 0; m_mc = 0; m_upd_pc = 0;
        m_upd_valid = 0; m_upd_out = 0; m_mis = 0;
    endfunction

    // Applies one rising edge worth of queue rules to the model.
    function automatic void model_edge(bit pv, int ppc, bit pt, bit rv, bit rt);
        bit can_push, do_pop, miss;
        can_push = (m_pc.size() < DP);
        do_pop = rv && (m_pc.size() > 0);
        miss = 0;
        m_upd_valid = do_pop;
        if (do_pop) begin
            miss = (m_tk[0] != rt);
            m_upd_pc = m_pc[0];
            m_upd_out = rt;
            if (m_bc < CMAX) m_bc++;
            if (miss && m_mc < CMAX) m_mc++;
        end
        m_mis = miss;
        if (miss) begin
            m_pc.delete();
            m_tk.delete();
        end else begin
            if (do_pop) begin
                void'(m_pc.pop_front());
                void'(m_tk.pop_front());
            end
            if (pv && can_push) begin
                m_pc.push_back(ppc);
                m_tk.push_back(pt);
            end
        end
    endfunction

    task automatic step(input bit pv, input int ppc, input bit pt, input bit rv, input bit rt);
        pred_valid = pv;
        pred_pc = PW'(ppc);
        pred_taken = pt;
        res_valid = rv;
        res_taken = rt;
        @(posedge clk);
        model_edge(pv, ppc, pt, rv, rt);
        #1;
        pred_valid = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({occupancy, upd_valid, mispredict, upd_pc, upd_outcome} !== 14'd0)
            $display("FAIL reset_outputs: got occ=%0d uv=%0d mis=%0d pc=%0d out=%0d, want all 0",
                     occupancy, upd_valid, mispredict, upd_pc, upd_outcome);
        else n_pass++;
        n_checks++;
        if (branch_count !== 4'd0 || mispredict_count !== 4'd0)
            $display("FAIL reset_counters: got bc=%0d mc=%0d, want 0 0", branch_count, mispredict_count);
        else n_pass++;
        n_checks++;
        if (pred_ready !== 1'b1 || res_ready !== 1'b0)
            $display("FAIL reset_ready: got pred_ready=%0d res_ready=%0d, want 1 0", pred_ready, res_ready);
        else n_pass++;
    endtask

    task automatic test_in_order();
        int exp_pc[3] = '{10, 11, 12};
        bit exp_tk[3] = '{1, 0, 1};
        apply_reset();
        for (int i = 0; i < 3; i++) step(1, exp_pc[i], exp_tk[i], 0, 0);
        n_checks++;
        if (occupancy !== 3'd3) $display("FAIL inorder_occ: got %0d want 3", occupancy);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, exp_tk[i]);
            n_checks++;
            if (upd_valid !== 1'b1 || upd_pc !== PW'(exp_pc[i]) || upd_outcome !== exp_tk[i] || mispredict !== 1'b0)
                $display("FAIL inorder_upd%0d: got uv=%0d pc=%0d out=%0d mis=%0d, want 1 %0d %0d 0",
                         i, upd_valid, upd_pc, upd_outcome, mispredict, exp_pc[i], exp_tk[i]);
            else n_pass++;
        end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (upd_valid !== 1'b0 || branch_count !== 4'd3 || mispredict_count !== 4'd0 || occupancy !== 3'd0)
            $display("FAIL inorder_end: got uv=%0d bc=%0d mc=%0d occ=%0d, want 0 3 0 0",
                     upd_valid, branch_count, mispredict_count, occupancy);
        else n_pass++;
    endtask

    task automatic test_full_block();
        apply_reset();
        for (int i = 0; i < 4; i++) step(1, 40 + i, 1, 0, 0);
        n_checks++;
        if (pred_ready !== 1'b0 || occupancy !== 3'd4)
            $display("FAIL full_ready: got pred_ready=%0d occ=%0d, want 0 4", pred_ready, occupancy);
        else n_pass++;
        step(1, 99, 1, 1, 1);
        n_checks++;
        if (occupancy !== 3'd3 || upd_pc !== 8'd40 || mispredict !== 1'b0)
            $display("FAIL full_enq_blocked: got occ=%0d pc=%0d mis=%0d, want 3 40 0", occupancy, upd_pc, mispredict);
        else n_pass++;
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0, 1, 1);
            n_checks++;
            if (upd_valid !== 1'b1 || upd_pc !== PW'(40 + i))
                $display("FAIL full_drain%0d: got uv=%0d pc=%0d, want 1 %0d", i, upd_valid, upd_pc, 40 + i);
            else n_pass++;
        end
        n_checks++;
        if (res_ready !== 1'b0) $display("FAIL full_drained_empty: got res_ready=%0d want 0", res_ready);
        else n_pass++;
    endtask

    task automatic test_flush();
        apply_reset();
        step(1, 20, 1, 0, 0);
        step(1, 21, 0, 0, 0);
        step(1, 22, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        n_checks++;
        if (mispredict !== 1'b1 || upd_valid !== 1'b1 || upd_pc !== 8'd20 || upd_outcome !== 1'b0)
            $display("FAIL flush_pulse: got mis=%0d uv=%0d pc=%0d out=%0d, want 1 1 20 0",
                     mispredict, upd_valid, upd_pc, upd_outcome);
        else n_pass++;
        n_checks++;
        if (occupancy !== 3'd0 || res_ready !== 1'b0 || mispredict_count !== 4'd1 || branch_count !== 4'd1)
            $display("FAIL flush_state: got occ=%0d rr=%0d mc=%0d bc=%0d, want 0 0 1 1",
                     occupancy, res_ready, mispredict_count, branch_count);
        else n_pass++;
        step(1, 25, 1, 0, 0);
        step(1, 30, 1, 1, 0);
        n_checks++;
        if (occupancy !== 3'd0 || mispredict !== 1'b1 || upd_pc !== 8'd25)
            $display("FAIL flush_wrongpath: got occ=%0d mis=%0d pc=%0d, want 0 1 25", occupancy, mispredict, upd_pc);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (mispredict !== 1'b0 || upd_valid !== 1'b0 || occupancy !== 3'd0)
            $display("FAIL flush_after: got mis=%0d uv=%0d occ=%0d, want 0 0 0", mispredict, upd_valid, occupancy);
        else n_pass++;
    endtask

    task automatic test_empty_resolve();
        apply_reset();
        step(0, 0, 0, 1, 1);
        n_checks++;
        if (upd_valid !== 1'b0 || mispredict !== 1'b0 || branch_count !== 4'd0 || mispredict_count !== 4'd0)
            $display("FAIL empty_resolve: got uv=%0d mis=%0d bc=%0d mc=%0d, want 0 0 0 0",
                     upd_valid, mispredict, branch_count, mispredict_count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(1, 50, 1, 0, 0);
        step(1, 51, 1, 0, 0);
        step(1, 52, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        n_checks++;
        if (occupancy !== 3'd2 || upd_valid !== 1'b1)
            $display("FAIL async_setup: got occ=%0d uv=%0d, want 2 1", occupancy, upd_valid);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (occupancy !== 3'd0 || upd_valid !== 1'b0 || mispredict !== 1'b0 ||
            branch_count !== 4'd0 || mispredict_count !== 4'd0)
            $display("FAIL async_reset: got occ=%0d uv=%0d mis=%0d bc=%0d mc=%0d, want all 0",
                     occupancy, upd_valid, mispredict, branch_count, mispredict_count);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            step(1, i, 1, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        n_checks++;
        if (branch_count !== 4'd15 || mispredict_count !== 4'd15)
            $display("FAIL saturate: got bc=%0d mc=%0d, want 15 15", branch_count, mispredict_count);
        else n_pass++;
    endtask

    task automatic test_random();
        bit pv, pt, rv, rt;
        int ppc;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            pv = ($urandom_range(0, 2) != 0);
            ppc = $urandom_range(0, 255);
            pt = $urandom_range(0, 1);
            rv = ($urandom_range(0, 1) == 1);
            if (m_tk.size() > 0)
                rt = ($urandom_range(0, 4) == 0) ? !m_tk[0] : m_tk[0];
            else
                rt = $urandom_range(0, 1);
            n_checks++;
            if (pred_ready !== (m_pc.size() < DP) || res_ready !== (m_pc.size() > 0))
                $display("FAIL rand_ready c%0d: got pr=%0d rr=%0d, want %0d %0d",
                         cyc, pred_ready, res_ready, m_pc.size() < DP, m_pc.size() > 0);
            else n_pass++;
            step(pv, ppc, pt, rv, rt);
            n_checks++;
            if (upd_valid !== m_upd_valid || mispredict !== m_mis ||
                (m_upd_valid && (upd_pc !== PW'(m_upd_pc) || upd_outcome !== m_upd_out)))
                $display("FAIL rand_upd c%0d: got uv=%0d mis=%0d pc=%0d out=%0d, want %0d %0d %0d %0d",
                         cyc, upd_valid, mispredict, upd_pc, upd_outcome, m_upd_valid, m_mis, m_upd_pc, m_upd_out);
            else n_pass++;
            n_checks++;
            if (occupancy !== 3'(m_pc.size()) || branch_count !== CW'(m_bc) || mispredict_count !== CW'(m_mc))
                $display("FAIL rand_state c%0d: got occ=%0d bc=%0d mc=%0d, want %0d %0d %0d",
                         cyc, occupancy, branch_count, mispredict_count, m_pc.size(), m_bc, m_mc);
            else n_pass++;
            if (cyc % 100 == 99) apply_reset();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_in_order();
        test_full_block();
        test_flush();
        test_empty_resolve();
        test_async_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
